// File: rtl/text_stream_reader_if.sv
// Handshake/bus bundle between text_stream_reader, the text memory and the
// braille converter. The master side is the reader.
interface text_stream_reader_if;
    logic [7:0] mem_addr;
    logic [7:0] mem_dout;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic       char_last;

    modport master (
        output mem_addr,
        output char_data,
        output char_valid,
        output char_last,
        input  mem_dout,
        input  char_ready
    );

    modport slave (
        input  mem_addr,
        input  char_data,
        input  char_valid,
        input  char_last,
        output mem_dout,
        output char_ready
    );
endinterface

// File: rtl/text_stream_reader.sv
// text_stream_reader: scans a terminated ASCII string in text memory to find
// its length, then re-reads it and streams one character per valid/ready
// handshake to the braille converter.
// Optional feature macro: CASE_FOLD_EN (fold 'a'..'z' to upper case on output).
module text_stream_reader #(
    parameter logic [7:0]  BASE_ADDR = 8'h00,
    parameter int unsigned MAX_LEN   = 256,
    parameter logic [7:0]  TERM_CHAR = 8'h00
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    text_stream_reader_if.master        bus,
    output logic [8:0]                  length,
    output logic                        busy,
    output logic                        done
);

    localparam logic [8:0] MAX_IDX = 9'(MAX_LEN);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        STREAM,
        FIN
    } state_t;

    state_t     state_q;
    logic [8:0] idx_q;
    logic [8:0] length_q;
    logic [7:0] char_data_q;
    logic       char_valid_q;
    logic       char_last_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] char_d;

    // Character presented to the output register (optionally case-folded).
    always_comb begin
        char_d = bus.mem_dout;
`ifdef CASE_FOLD_EN
        if (bus.mem_dout >= 8'h61 && bus.mem_dout <= 8'h7A)
            char_d = bus.mem_dout - 8'h20;
`else
        char_d = bus.mem_dout;
`endif
    end

    // Memory address follows idx while scanning/streaming, parks on the base otherwise.
    always_comb begin
        bus.mem_addr = BASE_ADDR;
        if (state_q == SCAN || state_q == STREAM)
            bus.mem_addr = BASE_ADDR + idx_q[7:0];
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            length_q     <= '0;
            char_data_q  <= '0;
            char_valid_q <= 1'b0;
            char_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q    <= '0;
                        length_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SCAN;
                    end
                end
                SCAN: begin
                    if (bus.mem_dout == TERM_CHAR || idx_q == MAX_IDX) begin
                        length_q <= idx_q;
                        idx_q    <= '0;
                        if (idx_q != '0) begin
                            state_q <= STREAM;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= FIN;
                        end
                    end else begin
                        idx_q <= idx_q + 9'd1;
                    end
                end
                STREAM: begin
                    if (char_valid_q && bus.char_ready && char_last_q) begin
                        char_valid_q <= 1'b0;
                        char_last_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= FIN;
                    end else if ((!char_valid_q || bus.char_ready) && idx_q < length_q) begin
                        char_data_q  <= char_d;
                        char_valid_q <= 1'b1;
                        char_last_q  <= (idx_q == length_q - 9'd1);
                        idx_q        <= idx_q + 9'd1;
                    end else if (bus.char_ready) begin
                        char_valid_q <= 1'b0;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.char_data  = char_data_q;
    assign bus.char_valid = char_valid_q;
    assign bus.char_last  = char_last_q;
    assign length         = length_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule
